// File: rtl/spi_frame_reader.sv
// SPI mode-0 flash reader: issues a read command plus 24-bit address, then streams
// MISO bits as 1-bit pixels into an X_WIDTH x Y_HEIGHT video bank, pausing for bank swaps.
module spi_frame_reader #(
  parameter int          X_WIDTH  = 200,
  parameter int          Y_HEIGHT = 150,
  parameter logic [7:0]  READ_CMD = 8'h03
) (
  input  logic                        CLK_40,
  input  logic                        reset,
  input  logic                        SPI_clk_en,
  input  logic                        start,
  input  logic                        abort,
  input  logic [23:0]                 start_addr,
  input  logic                        swap_ack,
  input  logic                        MISO,
  output logic                        SCLK,
  output logic                        MOSI,
  output logic                        CS_n,
  output logic                        write_enable,
  output logic                        data_out,
  output logic [$clog2(X_WIDTH)-1:0]  mem_x_pos,
  output logic [$clog2(Y_HEIGHT)-1:0] mem_y_pos,
  output logic                        frame_done,
  output logic                        busy,
  output logic [15:0]                 frame_count,
  output logic [2:0]                  state
);

  localparam int XW = $clog2(X_WIDTH);
  localparam int YW = $clog2(Y_HEIGHT);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CMD       = 3'd1,
    S_ADDR      = 3'd2,
    S_STREAM    = 3'd3,
    S_WAIT_SWAP = 3'd4
  } state_t;

  state_t      st;
  logic [30:0] shift_reg;
  logic [4:0]  bit_cnt;
  logic        x_last;
  logic        y_last;

  assign state  = st;
  assign x_last = (mem_x_pos == XW'(X_WIDTH - 1));
  assign y_last = (mem_y_pos == YW'(Y_HEIGHT - 1));

  always_ff @(posedge CLK_40) begin
    if (reset) begin
      st           <= S_IDLE;
      SCLK         <= 1'b0;
      MOSI         <= 1'b0;
      CS_n         <= 1'b1;
      write_enable <= 1'b0;
      data_out     <= 1'b0;
      mem_x_pos    <= '0;
      mem_y_pos    <= '0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
      frame_count  <= 16'd0;
      shift_reg    <= '0;
      bit_cnt      <= 5'd0;
    end else begin
      write_enable <= 1'b0;
      frame_done   <= 1'b0;
      if (abort && st != S_IDLE) begin
        st        <= S_IDLE;
        CS_n      <= 1'b1;
        SCLK      <= 1'b0;
        MOSI      <= 1'b0;
        mem_x_pos <= '0;
        mem_y_pos <= '0;
        busy      <= 1'b0;
      end else begin
        case (st)
          S_IDLE: begin
            // Abort held with start keeps the reader idle.
            if (start && !abort) begin
              st        <= S_CMD;
              CS_n      <= 1'b0;
              MOSI      <= READ_CMD[7];
              shift_reg <= {READ_CMD[6:0], start_addr};
              bit_cnt   <= 5'd0;
              busy      <= 1'b1;
            end
          end
          S_CMD, S_ADDR: begin
            if (SPI_clk_en) begin
              SCLK <= ~SCLK;
              if (SCLK) begin
                // Falling edge: the bit in bit_cnt has been clocked out.
                bit_cnt <= bit_cnt + 5'd1;
                if (bit_cnt == 5'd31) begin
                  st   <= S_STREAM;
                  MOSI <= 1'b0;
                end else begin
                  MOSI      <= shift_reg[30];
                  shift_reg <= {shift_reg[29:0], 1'b0};
                  if (bit_cnt == 5'd7) st <= S_ADDR;
                end
              end
            end
          end
          S_STREAM: begin
            // Address advances in the cycle after its write pulse.
            if (write_enable) begin
              if (x_last && y_last) begin
                mem_x_pos <= '0;
                mem_y_pos <= '0;
                st        <= S_WAIT_SWAP;
              end else if (x_last) begin
                mem_x_pos <= '0;
                mem_y_pos <= mem_y_pos + 1'b1;
              end else begin
                mem_x_pos <= mem_x_pos + 1'b1;
              end
            end
            if (SPI_clk_en) begin
              SCLK <= ~SCLK;
              if (!SCLK) begin
                data_out     <= MISO;
                write_enable <= 1'b1;
                if (x_last && y_last) begin
                  frame_done  <= 1'b1;
                  frame_count <= frame_count + 16'd1;
                end
              end
            end
          end
          S_WAIT_SWAP: begin
            if (SPI_clk_en && SCLK) SCLK <= 1'b0;
            if (swap_ack) st <= S_STREAM;
          end
          default: st <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_reader.sv
// Directed bench for spi_frame_reader (8x6 frame): drivers push expected MOSI bits and
// pixel writes into queues; a negedge monitor pops and compares them.
module tb_spi_frame_reader;

  localparam int         XW_P = 8;
  localparam int         YH_P = 6;
  localparam logic [7:0] RCMD = 8'h03;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_CMD = 3'd1, ST_ADDR = 3'd2,
                         ST_STREAM = 3'd3, ST_WAIT = 3'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        SPI_clk_en = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [23:0] start_addr = 24'd0;
  logic        swap_ack = 1'b0;
  logic        MISO = 1'b0;
  logic        SCLK, MOSI, CS_n, write_enable, data_out, frame_done, busy;
  logic [2:0]  mem_x_pos, mem_y_pos, state;
  logic [15:0] frame_count;

  spi_frame_reader #(.X_WIDTH(XW_P), .Y_HEIGHT(YH_P), .READ_CMD(RCMD)) dut (
    .CLK_40(clk), .reset(reset), .SPI_clk_en(SPI_clk_en), .start(start), .abort(abort),
    .start_addr(start_addr), .swap_ack(swap_ack), .MISO(MISO), .SCLK(SCLK), .MOSI(MOSI),
    .CS_n(CS_n), .write_enable(write_enable), .data_out(data_out), .mem_x_pos(mem_x_pos),
    .mem_y_pos(mem_y_pos), .frame_done(frame_done), .busy(busy), .frame_count(frame_count),
    .state(state)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;
  int n_writes = 0;
  logic sclk_prev = 1'b0;
  logic       mosi_q[$];
  logic [7:0] wr_q[$];   // {frame_done, data, y, x}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: pixel writes and MOSI bits at each SCLK rise.
  always @(negedge clk) begin
    if (write_enable === 1'b1) begin
      n_writes++;
      if (wr_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_write: x=%0d y=%0d at %0t", mem_x_pos, mem_y_pos, $time);
      end else begin
        check("pixel_write", {24'd0, frame_done, data_out, mem_y_pos, mem_x_pos}, {24'd0, wr_q.pop_front()});
      end
    end
    if (frame_done === 1'b1 && write_enable !== 1'b1) begin
      total++;
      $display("FAIL frame_done_alone: got 1 expected 0 at %0t", $time);
    end
    if (SCLK === 1'b1 && sclk_prev === 1'b0 && mosi_q.size() > 0)
      check("mosi_bit", {31'd0, MOSI}, {31'd0, mosi_q.pop_front()});
    sclk_prev = SCLK;
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic strobe();
    SPI_clk_en = 1'b1;
    tick();
    SPI_clk_en = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_start(input logic [23:0] addr);
    logic [31:0] word;
    word = {RCMD, addr};
    for (int i = 31; i >= 0; i--) mosi_q.push_back(word[i]);
    start_addr = addr;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One pixel: rise strobe (sample), optional swap_ack during the write cycle, fall strobe.
  task automatic pixel(input logic b, input int idx, input logic ack_on_write);
    logic [2:0] ex, ey;
    logic       fd;
    ex = 3'(idx % XW_P);
    ey = 3'(idx / XW_P);
    fd = (idx == XW_P * YH_P - 1);
    wr_q.push_back({fd, b, ey, ex});
    MISO = b;
    SPI_clk_en = 1'b1;
    tick();
    SPI_clk_en = 1'b0;
    swap_ack = ack_on_write;
    tick();
    swap_ack = 1'b0;
    tick();
    strobe();
  endtask

  logic [47:0] pat1 = 48'hB35A0FC6E197;
  logic [47:0] pat2 = 48'h6D29F04B1CA5;
  logic [9:0]  pat3 = 10'b1011001110;
  int          sclk_seen;

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #2;
    check("rst_sclk", {31'd0, SCLK}, 0);
    check("rst_mosi", {31'd0, MOSI}, 0);
    check("rst_cs_n", {31'd0, CS_n}, 1);
    check("rst_we", {31'd0, write_enable}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_fcount", {16'd0, frame_count}, 0);
    check("rst_state", {29'd0, state}, ST_IDLE);
    reset = 1'b0;
    tick();

    // Command + address 0x123456
    do_start(24'h123456);
    check("start_cs_n", {31'd0, CS_n}, 0);
    check("start_mosi", {31'd0, MOSI}, {31'd0, RCMD[7]});
    check("start_state", {29'd0, state}, ST_CMD);
    check("start_busy", {31'd0, busy}, 1);
    for (int i = 0; i < 64; i++) strobe();
    check("cmd_done_state", {29'd0, state}, ST_STREAM);
    check("cmd_done_mosi", {31'd0, MOSI}, 0);

    // Frame 1; swap_ack coincides with frame_done and must be ignored
    for (int i = 0; i < 48; i++) pixel(pat1[47 - i], i, (i == 47));
    check("f1_state", {29'd0, state}, ST_WAIT);
    check("f1_fcount", {16'd0, frame_count}, 1);

    // Swap wait: 100 strobes with no ack
    for (int i = 0; i < 100; i++) strobe();
    check("wait_sclk", {31'd0, SCLK}, 0);
    check("wait_cs_n", {31'd0, CS_n}, 0);
    check("wait_state", {29'd0, state}, ST_WAIT);
    swap_ack = 1'b1;
    tick();
    swap_ack = 1'b0;
    check("swap_state", {29'd0, state}, ST_STREAM);

    // Frame 2 with a start attempt mid-stream
    for (int i = 0; i < 48; i++) begin
      if (i == 20) begin
        start_addr = 24'hFFFFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_stream_state", {29'd0, state}, ST_STREAM);
        check("start_in_stream_mosi", {31'd0, MOSI}, 0);
      end
      pixel(pat2[47 - i], i, 1'b0);
    end
    check("f2_fcount", {16'd0, frame_count}, 2);
    check("f2_state", {29'd0, state}, ST_WAIT);

    // Abort from WAIT_SWAP, then abort at ADDR bit 10
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_wait_state", {29'd0, state}, ST_IDLE);
    check("abort_keeps_fcount", {16'd0, frame_count}, 2);
    do_start(24'hABCDEF);
    for (int i = 0; i < 36; i++) strobe();
    check("pre_abort_state", {29'd0, state}, ST_ADDR);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    mosi_q.delete();
    check("abort_cs_n", {31'd0, CS_n}, 1);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_sclk", {31'd0, SCLK}, 0);
    check("abort_state", {29'd0, state}, ST_IDLE);

    // Abort and start together in IDLE
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("abort_start_state", {29'd0, state}, ST_IDLE);
    check("abort_start_cs_n", {31'd0, CS_n}, 1);

    // Restart with 0xABCDEF
    do_start(24'hABCDEF);
    check("restart_mosi", {31'd0, MOSI}, {31'd0, RCMD[7]});
    for (int i = 0; i < 64; i++) strobe();
    check("restart_state", {29'd0, state}, ST_STREAM);
    for (int i = 0; i < 10; i++) pixel(pat3[9 - i], i, 1'b0);

    // Reset for 2 cycles mid-stream
    reset = 1'b1;
    start = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("mrst_sclk", {31'd0, SCLK}, 0);
    check("mrst_mosi", {31'd0, MOSI}, 0);
    check("mrst_cs_n", {31'd0, CS_n}, 1);
    check("mrst_we", {31'd0, write_enable}, 0);
    check("mrst_data", {31'd0, data_out}, 0);
    check("mrst_xy", {26'd0, mem_y_pos, mem_x_pos}, 0);
    check("mrst_fdone", {31'd0, frame_done}, 0);
    check("mrst_busy", {31'd0, busy}, 0);
    check("mrst_fcount", {16'd0, frame_count}, 0);
    check("mrst_state", {29'd0, state}, ST_IDLE);
    sclk_seen = 0;
    for (int i = 0; i < 20; i++) begin
      strobe();
      if (SCLK !== 1'b0) sclk_seen++;
    end
    check("post_rst_sclk_quiet", sclk_seen, 0);

    // Scoreboard drained
    check("wr_q_empty", wr_q.size(), 0);
    check("mosi_q_empty", mosi_q.size(), 0);
    check("write_count", n_writes, 106);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
